// File: rtl/boid_swarm_engine.sv
// Boid swarm update engine: a four-cycle-per-boid sweep that applies edge turning, speed banding and integration.
// Optional build macro BOID_SPEED_CLAMP_EN enables the speed clamp; otherwise velocity passes through CLAMP unchanged.
module boid_swarm_engine #(
    parameter int                   N_BOIDS   = 4,
    parameter int                   W         = 32,
    parameter int                   FRAC      = 16,
    parameter logic signed [W-1:0]  X_MAX     = W'(640) << FRAC,
    parameter logic signed [W-1:0]  Y_MAX     = W'(480) << FRAC,
    parameter logic signed [W-1:0]  MARGIN    = W'(100) << FRAC,
    parameter logic signed [W-1:0]  TURN      = W'(1) << (FRAC - 1),
    parameter logic signed [W-1:0]  MIN_SPEED = W'(4) << FRAC,
    parameter logic signed [W-1:0]  MAX_SPEED = W'(8) << FRAC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                init_en,
    input  logic [5:0]          init_idx,
    input  logic signed [W-1:0] init_x,
    input  logic signed [W-1:0] init_y,
    input  logic signed [W-1:0] init_vx,
    input  logic signed [W-1:0] init_vy,
    input  logic [5:0]          rd_idx,
    output logic signed [W-1:0] rd_x,
    output logic signed [W-1:0] rd_y,
    output logic signed [W-1:0] rd_px,
    output logic signed [W-1:0] rd_py,
    output logic signed [W-1:0] rd_vx,
    output logic signed [W-1:0] rd_vy
);

    localparam int                  IW       = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1;
    localparam logic [IW-1:0]       LAST_IDX = IW'(N_BOIDS - 1);
    localparam logic [6:0]          N_LIM    = 7'(N_BOIDS);
    localparam logic signed [W-1:0] X_HI     = X_MAX - MARGIN;
    localparam logic signed [W-1:0] Y_HI     = Y_MAX - MARGIN;
    localparam logic signed [W-1:0] HOME_Y   = W'(240) << FRAC;
    localparam logic signed [W-1:0] HOME_V   = W'(4) << FRAC;
`ifdef BOID_SPEED_CLAMP_EN
    localparam bit                  CLAMP_EN = 1'b1;
`else
    localparam bit                  CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_SPEED = 3'd2,
        ST_CLAMP = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic signed [W-1:0] home_x(input int j);
        return W'(180 + 16 * j) << FRAC;
    endfunction

    function automatic logic signed [W-1:0] abs_w(input logic signed [W-1:0] v);
        if (v[W-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    logic signed [W-1:0] x_q  [N_BOIDS];
    logic signed [W-1:0] y_q  [N_BOIDS];
    logic signed [W-1:0] px_q [N_BOIDS];
    logic signed [W-1:0] py_q [N_BOIDS];
    logic signed [W-1:0] vx_q [N_BOIDS];
    logic signed [W-1:0] vy_q [N_BOIDS];

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                load_s;
    logic                busy_q, done_q;
    logic signed [W-1:0] wx_q, wy_q, wvx_q, wvy_q, speed_q;
    logic signed [W-1:0] turn_vx_s, turn_vy_s, clamp_vx_s, clamp_vy_s;
    logic signed [W-1:0] ax_s, ay_s, speed_s;
    logic                wr_en_s;
    logic [IW-1:0]       wr_idx_s;
    logic signed [W-1:0] wr_x_s, wr_y_s, wr_px_s, wr_py_s, wr_vx_s, wr_vy_s;

    // Sweep sequencing: next state, boid index and working-register load strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TURN;
                    idx_d   = '0;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN:  state_d = ST_SPEED;
            ST_SPEED: state_d = ST_CLAMP;
            ST_CLAMP: state_d = ST_WRITE;
            ST_WRITE: begin
                if (idx_q != LAST_IDX) begin
                    state_d = ST_TURN;
                    idx_d   = idx_q + IW'(1);
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Edge turning, speed estimate and speed banding on the working copy.
    always_comb begin
        turn_vx_s = wvx_q;
        turn_vy_s = wvy_q;
        if (wx_q < MARGIN) begin
            turn_vx_s = wvx_q + TURN;
        end else if (wx_q > X_HI) begin
            turn_vx_s = wvx_q - TURN;
        end else begin
            turn_vx_s = wvx_q;
        end
        if (wy_q < MARGIN) begin
            turn_vy_s = wvy_q + TURN;
        end else if (wy_q > Y_HI) begin
            turn_vy_s = wvy_q - TURN;
        end else begin
            turn_vy_s = wvy_q;
        end
        ax_s = abs_w(wvx_q);
        ay_s = abs_w(wvy_q);
        if (ax_s > ay_s) begin
            speed_s = ax_s + (ay_s >>> 1);
        end else begin
            speed_s = ay_s + (ax_s >>> 1);
        end
        if (CLAMP_EN && (speed_q > MAX_SPEED)) begin
            clamp_vx_s = wvx_q - (wvx_q >>> 2);
            clamp_vy_s = wvy_q - (wvy_q >>> 2);
        end else if (CLAMP_EN && (speed_q < MIN_SPEED)) begin
            clamp_vx_s = wvx_q + (wvx_q >>> 2);
            clamp_vy_s = wvy_q + (wvy_q >>> 2);
        end else begin
            clamp_vx_s = wvx_q;
            clamp_vy_s = wvy_q;
        end
    end

    // Working registers: load a boid, then refine its velocity stage by stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wx_q    <= '0;
            wy_q    <= '0;
            wvx_q   <= '0;
            wvy_q   <= '0;
            speed_q <= '0;
        end else begin
            if (load_s) begin
                wx_q  <= x_q[idx_d];
                wy_q  <= y_q[idx_d];
                wvx_q <= vx_q[idx_d];
                wvy_q <= vy_q[idx_d];
            end
            case (state_q)
                ST_TURN: begin
                    wvx_q <= turn_vx_s;
                    wvy_q <= turn_vy_s;
                end
                ST_SPEED: speed_q <= speed_s;
                ST_CLAMP: begin
                    wvx_q <= clamp_vx_s;
                    wvy_q <= clamp_vy_s;
                end
                default: ;
            endcase
        end
    end

    // Store-port mux: sweep write-back, or a host init while idle with start low.
    always_comb begin
        wr_en_s  = 1'b0;
        wr_idx_s = idx_q;
        wr_x_s   = wx_q + wvx_q;
        wr_y_s   = wy_q + wvy_q;
        wr_px_s  = wx_q;
        wr_py_s  = wy_q;
        wr_vx_s  = wvx_q;
        wr_vy_s  = wvy_q;
        if (state_q == ST_WRITE) begin
            wr_en_s = 1'b1;
        end else if ((state_q == ST_IDLE) && init_en && !start && ({1'b0, init_idx} < N_LIM)) begin
            wr_en_s  = 1'b1;
            wr_idx_s = init_idx[IW-1:0];
            wr_x_s   = init_x;
            wr_y_s   = init_y;
            wr_px_s  = init_x;
            wr_py_s  = init_y;
            wr_vx_s  = init_vx;
            wr_vy_s  = init_vy;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Boid state storage; reset places the flock in a row at mid-height.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N_BOIDS; j++) begin
                x_q[j]  <= home_x(j);
                px_q[j] <= home_x(j);
                y_q[j]  <= HOME_Y;
                py_q[j] <= HOME_Y;
                vx_q[j] <= HOME_V;
                vy_q[j] <= HOME_V;
            end
        end else if (wr_en_s) begin
            x_q[wr_idx_s]  <= wr_x_s;
            y_q[wr_idx_s]  <= wr_y_s;
            px_q[wr_idx_s] <= wr_px_s;
            py_q[wr_idx_s] <= wr_py_s;
            vx_q[wr_idx_s] <= wr_vx_s;
            vy_q[wr_idx_s] <= wr_vy_s;
        end
    end

    // Combinational read port; out-of-range selects read as zero.
    always_comb begin
        if ({1'b0, rd_idx} < N_LIM) begin
            rd_x  = x_q[rd_idx[IW-1:0]];
            rd_y  = y_q[rd_idx[IW-1:0]];
            rd_px = px_q[rd_idx[IW-1:0]];
            rd_py = py_q[rd_idx[IW-1:0]];
            rd_vx = vx_q[rd_idx[IW-1:0]];
            rd_vy = vy_q[rd_idx[IW-1:0]];
        end else begin
            rd_x  = '0;
            rd_y  = '0;
            rd_px = '0;
            rd_py = '0;
            rd_vx = '0;
            rd_vy = '0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_boid_swarm_engine.sv
// Directed self-checking bench for boid_swarm_engine (default parameters, N_BOIDS=4, W=32, FRAC=16).
module tb_boid_swarm_engine;

`ifdef BOID_SPEED_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, start, busy, done, init_en;
    logic [5:0]         init_idx, rd_idx;
    logic signed [31:0] init_x, init_y, init_vx, init_vy;
    logic signed [31:0] rd_x, rd_y, rd_px, rd_py, rd_vx, rd_vy;
    int                 checks = 0;
    int                 errors = 0;
    int                 done_cnt = 0;

    boid_swarm_engine dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .init_en(init_en), .init_idx(init_idx),
        .init_x(init_x), .init_y(init_y), .init_vx(init_vx), .init_vy(init_vy),
        .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_px(rd_px), .rd_py(rd_py), .rd_vx(rd_vx), .rd_vy(rd_vy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_boid(input logic [5:0] idx, input logic signed [31:0] x, y, vx, vy);
        init_en = 1'b1; init_idx = idx; init_x = x; init_y = y; init_vx = vx; init_vy = vy;
        tick;
        init_en = 1'b0;
    endtask

    task automatic read_boid(input logic [5:0] idx);
        rd_idx = idx;
        #1;
    endtask

    task automatic run_sweep(output logic early, output logic on_time, output logic idle_after);
        early = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < 16; c++) begin
            tick;
            if (done === 1'b1) early = 1'b1;
        end
        tick;
        on_time = (done === 1'b1) && (busy === 1'b1);
        tick;
        idle_after = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset;
        logic signed [31:0] ex;
        reset = 1'b1;
        repeat (2) tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
        end
        reset = 1'b0;
        tick;
        for (int j = 0; j < 4; j++) begin
            ex = 32'((180 + 16 * j) << 16);
            read_boid(6'(j));
            checks++;
            if (rd_x !== ex || rd_px !== ex || rd_y !== 32'sd15728640 || rd_py !== 32'sd15728640 ||
                rd_vx !== 32'sd262144 || rd_vy !== 32'sd262144) begin
                errors++;
                $display("FAIL reset_boid%0d got x=%0d px=%0d y=%0d vx=%0d vy=%0d want x=px=%0d y=15728640 v=262144",
                         j, rd_x, rd_px, rd_y, rd_vx, rd_vy, ex);
            end
        end
        read_boid(6'd7);
        checks++;
        if ({rd_x, rd_y, rd_px, rd_py, rd_vx, rd_vy} !== 192'd0) begin
            errors++; $display("FAIL reset_rd_oob got x=%0d y=%0d want all zero", rd_x, rd_y);
        end
    endtask

    task automatic test_basic_sweep;
        logic early, on_time, idle_after;
        run_sweep(early, on_time, idle_after);
        checks++;
        if (early !== 1'b0 || on_time !== 1'b1 || idle_after !== 1'b1) begin
            errors++; $display("FAIL basic_latency early=%b on_time=%b idle_after=%b want 0 1 1", early, on_time, idle_after);
        end
        read_boid(6'd0);
        checks++;
        if (rd_x !== 32'sd12058624 || rd_y !== 32'sd15990784 || rd_px !== 32'sd11796480 || rd_py !== 32'sd15728640) begin
            errors++; $display("FAIL basic_boid0 got x=%0d y=%0d px=%0d py=%0d want 12058624 15990784 11796480 15728640",
                               rd_x, rd_y, rd_px, rd_py);
        end
        read_boid(6'd3);
        checks++;
        if (rd_x !== 32'sd15204352 || rd_vx !== 32'sd262144) begin
            errors++; $display("FAIL basic_boid3 got x=%0d vx=%0d want 15204352 262144", rd_x, rd_vx);
        end
    endtask

    task automatic test_turn;
        logic early, on_time, idle_after;
        set_boid(6'd1, 32'sd3276800, 32'sd15728640, 32'sd0, 32'sd0);
        set_boid(6'd2, 32'sd39321600, 32'sd15728640, 32'sd262144, 32'sd262144);
        read_boid(6'd1);
        checks++;
        if (rd_x !== 32'sd3276800 || rd_px !== 32'sd3276800 || rd_vx !== 32'sd0) begin
            errors++; $display("FAIL init_boid1 got x=%0d px=%0d vx=%0d want 3276800 3276800 0", rd_x, rd_px, rd_vx);
        end
        run_sweep(early, on_time, idle_after);
        read_boid(6'd1);
        checks++;
        if (rd_vx !== (CLAMP ? 32'sd40960 : 32'sd32768) || rd_vy !== 32'sd0 ||
            rd_x !== (CLAMP ? 32'sd3317760 : 32'sd3309568) || rd_px !== 32'sd3276800) begin
            errors++; $display("FAIL turn_left got vx=%0d vy=%0d x=%0d px=%0d clamp=%0d", rd_vx, rd_vy, rd_x, rd_px, CLAMP);
        end
        read_boid(6'd2);
        checks++;
        if (rd_vx !== 32'sd229376 || rd_vy !== 32'sd262144 || rd_x !== 32'sd39550976 || rd_y !== 32'sd15990784) begin
            errors++; $display("FAIL turn_right got vx=%0d vy=%0d x=%0d y=%0d want 229376 262144 39550976 15990784",
                               rd_vx, rd_vy, rd_x, rd_y);
        end
    endtask

    task automatic test_clamp;
        logic early, on_time, idle_after;
        set_boid(6'd0, 32'sd6553600, 32'sd15728640, 32'sd262144, 32'sd262144);
        set_boid(6'd2, 32'sd19660800, 32'sd15728640, 32'sd524288, 32'sd524288);
        set_boid(6'd3, 32'sd19660800, 32'sd13107200, 32'sd524288, 32'sd0);
        run_sweep(early, on_time, idle_after);
        read_boid(6'd0);
        checks++;
        if (rd_vx !== 32'sd262144 || rd_x !== 32'sd6815744 || rd_y !== 32'sd15990784) begin
            errors++; $display("FAIL margin_equal got vx=%0d x=%0d y=%0d want 262144 6815744 15990784", rd_vx, rd_x, rd_y);
        end
        read_boid(6'd2);
        checks++;
        if (rd_vx !== (CLAMP ? 32'sd393216 : 32'sd524288) || rd_vy !== (CLAMP ? 32'sd393216 : 32'sd524288) ||
            rd_x !== (CLAMP ? 32'sd20054016 : 32'sd20185088)) begin
            errors++; $display("FAIL clamp_fast got vx=%0d vy=%0d x=%0d clamp=%0d", rd_vx, rd_vy, rd_x, CLAMP);
        end
        read_boid(6'd3);
        checks++;
        if (rd_vx !== 32'sd524288 || rd_vy !== 32'sd0 || rd_x !== 32'sd20185088) begin
            errors++; $display("FAIL clamp_equal got vx=%0d vy=%0d x=%0d want 524288 0 20185088", rd_vx, rd_vy, rd_x);
        end
    endtask

    task automatic test_busy_ignore;
        int c0;
        c0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        start = 1'b1; init_en = 1'b1; init_idx = 6'd0;
        init_x = 32'sd65536; init_y = 32'sd65536; init_vx = 32'sd0; init_vy = 32'sd0;
        tick;
        start = 1'b0; init_en = 1'b0;
        repeat (10) tick;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL busy_done_early got %b want 0", done);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL busy_done_time got %b want 1", done);
        end
        repeat (5) tick;
        checks++;
        if (busy !== 1'b0 || done_cnt - c0 !== 1) begin
            errors++; $display("FAIL busy_no_queue busy=%b done_pulses=%0d want 0 1", busy, done_cnt - c0);
        end
        read_boid(6'd0);
        checks++;
        if (rd_x !== 32'sd7077888 || rd_y !== 32'sd16252928) begin
            errors++; $display("FAIL busy_init_ignored got x=%0d y=%0d want 7077888 16252928", rd_x, rd_y);
        end
    endtask

    task automatic test_midreset;
        logic signed [31:0] ex;
        int c0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        c0 = done_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_async busy=%b done=%b want 0 0", busy, done);
        end
        repeat (2) tick;
        reset = 1'b0;
        repeat (20) tick;
        checks++;
        if (busy !== 1'b0 || done_cnt !== c0) begin
            errors++; $display("FAIL midreset_nodone busy=%b done_pulses=%0d want 0 0", busy, done_cnt - c0);
        end
        for (int j = 0; j < 4; j++) begin
            ex = 32'((180 + 16 * j) << 16);
            read_boid(6'(j));
            checks++;
            if (rd_x !== ex || rd_px !== ex || rd_y !== 32'sd15728640 || rd_vx !== 32'sd262144 || rd_vy !== 32'sd262144) begin
                errors++; $display("FAIL midreset_boid%0d got x=%0d px=%0d y=%0d vx=%0d want x=%0d", j, rd_x, rd_px, rd_y, rd_vx, ex);
            end
        end
    endtask

    task automatic test_wrap;
        logic early, on_time, idle_after;
        set_boid(6'd0, 32'sh7FFFFFFF, 32'sd15728640, 32'sd32769, 32'sd0);
        set_boid(6'd5, 32'sd0, 32'sd0, 32'sd1, 32'sd1);
        run_sweep(early, on_time, idle_after);
        read_boid(6'd0);
        checks++;
        if (rd_x !== 32'sh80000000 || rd_px !== 32'sh7FFFFFFF || rd_vx !== 32'sd1 || rd_vy !== 32'sd0) begin
            errors++; $display("FAIL wrap_x got x=%h px=%h vx=%0d vy=%0d want 80000000 7fffffff 1 0", rd_x, rd_px, rd_vx, rd_vy);
        end
        read_boid(6'd5);
        checks++;
        if ({rd_x, rd_y, rd_px, rd_py, rd_vx, rd_vy} !== 192'd0) begin
            errors++; $display("FAIL oob_idx5 got x=%0d vx=%0d want all zero", rd_x, rd_vx);
        end
        read_boid(6'd7);
        checks++;
        if ({rd_x, rd_y, rd_px, rd_py, rd_vx, rd_vy} !== 192'd0) begin
            errors++; $display("FAIL oob_idx7 got x=%0d y=%0d want all zero", rd_x, rd_y);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; init_en = 1'b0; init_idx = 6'd0; rd_idx = 6'd0;
        init_x = 32'sd0; init_y = 32'sd0; init_vx = 32'sd0; init_vy = 32'sd0;
        test_reset;
        test_basic_sweep;
        test_turn;
        test_clamp;
        test_busy_ignore;
        test_midreset;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
